// File: rtl/twiddle_mult_stage_pkg.sv
// Shared defaults and elaboration-time helpers for the radix-2^2 twiddle stage.
// The twiddle generator evaluates sin/cos in Q30 fixed point, so tables are bit-exact across tools.
package twiddle_mult_stage_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int TW_WIDTH_DEF   = 16;
  localparam int TW_FRAC_DEF    = 14;

  function automatic bit n_is_legal(input int n);
    return (n == 16) || (n == 64) || (n == 256);
  endfunction

  // Returns round(2^frac*cos(2*pi*e/n)) or -round(2^frac*sin(2*pi*e/n)).
  // Rounding is half away from zero.
  function automatic int tw_value(input int e, input int n_pts, input bit want_nsin, input int frac);
    longint two_pi_q30, x, x2, term, s_acc, c_acc, cv, sv, val, mag;
    int     quarter, q, r;
    two_pi_q30 = 64'sd6746518852;
    quarter    = n_pts / 4;
    q          = (e / quarter) % 4;
    r          = e % quarter;
    // Reduce to the first quadrant so the Taylor series converges quickly.
    x     = (two_pi_q30 * longint'(r)) / longint'(n_pts);
    x2    = (x * x) >>> 30;
    s_acc = x;
    term  = x;
    for (int i = 1; i <= 10; i++) begin
      term  = ((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
      s_acc = (i % 2 == 1) ? s_acc - term : s_acc + term;
    end
    c_acc = 64'sd1073741824;
    term  = c_acc;
    for (int i = 1; i <= 10; i++) begin
      term  = ((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      c_acc = (i % 2 == 1) ? c_acc - term : c_acc + term;
    end
    case (q)
      0:       begin cv =  c_acc; sv =  s_acc; end
      1:       begin cv = -s_acc; sv =  c_acc; end
      2:       begin cv = -c_acc; sv = -s_acc; end
      default: begin cv =  s_acc; sv = -c_acc; end
    endcase
    val = want_nsin ? -sv : cv;
    mag = (val < 0) ? -val : val;
    mag = (mag + (64'sd1 <<< (29 - frac))) >>> (30 - frac);
    return int'((val < 0) ? -mag : mag);
  endfunction

endpackage

// File: rtl/twiddle_mult_stage_if.sv
// Sample stream into and product stream out of the twiddle multiplier stage.
interface twiddle_mult_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int P          = 32
);
  logic                         i_valid;
  logic                         i_sync;
  logic signed [DATA_WIDTH-1:0] i_real;
  logic signed [DATA_WIDTH-1:0] i_imag;
  logic                         o_valid;
  logic                         o_frame_start;
  logic signed [P-1:0]          o_real;
  logic signed [P-1:0]          o_imag;

  modport master (
    output i_valid, i_sync, i_real, i_imag,
    input  o_valid, o_frame_start, o_real, o_imag
  );

  modport slave (
    input  i_valid, i_sync, i_real, i_imag,
    output o_valid, o_frame_start, o_real, o_imag
  );
endinterface

// File: rtl/twiddle_mult_stage_rom.sv
// Registered-read twiddle ROM: entry e = (cos, -sin) of 2*pi*e/N in Q2.(TW_WIDTH-2).
// Tables are generated at elaboration for each legal N.
module twiddle_rom
  import twiddle_mult_stage_pkg::*;
#(
  parameter int N        = 64,
  parameter int TW_WIDTH = TW_WIDTH_DEF
) (
  input  logic                       i_clk,
  input  logic [$clog2(N)-1:0]       i_addr,
  output logic signed [TW_WIDTH-1:0] o_cos,
  output logic signed [TW_WIDTH-1:0] o_nsin
);

  if (!n_is_legal(N)) begin : g_bad_n
    $fatal(1, "twiddle_rom: N must be 16, 64 or 256");
  end

  typedef logic [N-1:0][TW_WIDTH-1:0] tbl_t;

  function automatic tbl_t build_tbl(input bit want_nsin);
    tbl_t t;
    for (int e = 0; e < N; e++) t[e] = TW_WIDTH'(tw_value(e, N, want_nsin, TW_WIDTH - 2));
    return t;
  endfunction

  localparam tbl_t COS_TBL  = build_tbl(1'b0);
  localparam tbl_t NSIN_TBL = build_tbl(1'b1);

  always_ff @(posedge i_clk) begin
    o_cos  <= COS_TBL[i_addr];
    o_nsin <= NSIN_TBL[i_addr];
  end

endmodule

// File: rtl/twiddle_mult_stage.sv
// Streaming complex multiply by W_N^e between BF2I/BF2II; full-precision products out.
// Three register stages: ROM read + data, partial products, combine.
module twiddle_mult_stage
  import twiddle_mult_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_WIDTH   = TW_WIDTH_DEF,
  parameter int TW_FRAC    = TW_FRAC_DEF,
  parameter int N          = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  twiddle_mult_stage_if.slave bus
);

  localparam int P      = DATA_WIDTH + TW_WIDTH;
  localparam int PW     = P - 1;
  localparam int AW     = $clog2(N);
  localparam int NW     = AW - 2;
  localparam int STAGES = 3;

  if (TW_FRAC != TW_WIDTH - 2) begin : g_bad_frac
    $fatal(1, "twiddle_mult_stage: twiddles are Q2.x, TW_FRAC must be TW_WIDTH-2");
  end

  logic [AW-1:0]                k_cnt, k_cur, exp_e;
  logic [1:0]                   grp;
  logic [NW-1:0]                n_idx;
  logic signed [TW_WIDTH-1:0]   tw_cos, tw_nsin;
  logic [STAGES:1]              vld_pipe, fs_pipe;
  logic signed [DATA_WIDTH-1:0] a_s1, b_s1;
  logic signed [PW-1:0]         ac, bd, ad, bc;
  logic signed [P-1:0]          re_q, im_q;

  // Sync forces k=0 for the sample carrying it, regardless of the running count.
  always_comb begin
    k_cur = bus.i_sync ? '0 : k_cnt;
    grp   = k_cur[AW-1 -: 2];
    n_idx = k_cur[NW-1:0];
    case (grp)
      2'd0:    exp_e = '0;
      2'd1:    exp_e = AW'({n_idx, 1'b0});
      2'd2:    exp_e = AW'(n_idx);
      default: exp_e = AW'({n_idx, 1'b0}) + AW'(n_idx);
    endcase
  end

  twiddle_rom #(.N(N), .TW_WIDTH(TW_WIDTH)) u_rom (
    .i_clk  (i_clk),
    .i_addr (exp_e),
    .o_cos  (tw_cos),
    .o_nsin (tw_nsin)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k_cnt    <= '0;
      vld_pipe <= '0;
      fs_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.i_valid};
      fs_pipe  <= {fs_pipe[STAGES-1:1], bus.i_valid && (k_cur == '0)};
      // N is a power of two, so the AW-bit increment wraps N-1 to 0.
      if (bus.i_valid) k_cnt <= k_cur + AW'(1);
    end
  end

  // Data stages load only with their valid; outputs hold across gaps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_s1 <= '0;
      b_s1 <= '0;
      ac   <= '0;
      bd   <= '0;
      ad   <= '0;
      bc   <= '0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      if (bus.i_valid) begin
        a_s1 <= bus.i_real;
        b_s1 <= bus.i_imag;
      end
      // |twiddle| <= 2^TW_FRAC keeps every product inside PW bits.
      if (vld_pipe[1]) begin
        ac <= PW'(a_s1) * PW'(tw_cos);
        bd <= PW'(b_s1) * PW'(tw_nsin);
        ad <= PW'(a_s1) * PW'(tw_nsin);
        bc <= PW'(b_s1) * PW'(tw_cos);
      end
      if (vld_pipe[2]) begin
        re_q <= P'(ac) - P'(bd);
        im_q <= P'(ad) + P'(bc);
      end
    end
  end

  assign bus.o_valid       = vld_pipe[STAGES];
  assign bus.o_frame_start = fs_pipe[STAGES];
  assign bus.o_real        = re_q;
  assign bus.o_imag        = im_q;

endmodule
